validity_arbiter: RTL and testbench
===================================

Name: validity_arbiter

Overview:
- Round-robin scheduler that shares one validity_reg comparator (one-cycle registered equality check, enable-gated) among N_REQ requesters.
- Each requester presents an operand pair.
- The block grants one requester, drives the comparator operands and enable, and captures the registered result.
- It returns a done/match handshake and keeps saturating match/mismatch counters for the perf_sys statistics path.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- WIDTH, 3, operand width (matches the comparator input width).
- CNT_W, 8, width of the match and mismatch counters.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req  in  N_REQ  per-requester level request; four-phase handshake.
- a_flat  in  N_REQ*WIDTH  operand A of each requester; requester i uses bits [i*WIDTH +: WIDTH].
- b_flat  in  N_REQ*WIDTH  operand B of each requester, same packing.
- clr_cnt  in  1  synchronous clear of both counters.
- grant  out  N_REQ  one-hot registered grant; all zeros when idle.
- cmp_a  out  WIDTH  operand A to the shared comparator.
- cmp_b  out  WIDTH  operand B to the shared comparator.
- cmp_en  out  1  comparator enable (drives the comparator's enable/"reset" input).
- cmp_result  in  1  registered equality result from the comparator.
- done  out  N_REQ  one-cycle pulse to the served requester.
- match  out  1  captured result; valid while done is nonzero, held otherwise.
- busy  out  1  high in any state other than IDLE.
- match_cnt  out  CNT_W  saturating count of completed matches.
- miss_cnt  out  CNT_W  saturating count of completed mismatches.

Behaviour:
- Reset (asynchronous, reset=0):
  - state=IDLE; grant, done, match, cmp_en = 0.
  - Round-robin pointer = 0.
  - served[] = 0.
  - Both counters = 0.
- cmp_a and cmp_b:
  - Combinational mux of the granted requester's operands.
  - All zeros when grant=0.
- Eligibility: requester i is eligible when req[i]=1 and served[i]=0.
- served bit handling:
  - served[i] is set when done[i] is pulsed.
  - served[i] is cleared on any cycle where req[i]=0.
  - A requester must therefore drop req before it can be granted again.
- IDLE:
  - If any requester is eligible, pick the first eligible index at or after the pointer (wrapping modulo N_REQ).
  - Register the one-hot grant, set pointer = granted+1 mod N_REQ, and go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE (1 cycle):
  - cmp_en=1; the comparator samples the operands at the end of this cycle.
  - Go to CAPTURE.
- CAPTURE (1 cycle):
  - cmp_en=0.
  - At the end of the cycle: match <= cmp_result, done[g] <= 1, and the matching counter increments (saturating at 2^CNT_W-1).
  - Go to RESP.
- RESP (1 cycle):
  - done[g]=1 and grant held.
  - At the end of the cycle: done <= 0, grant <= 0, go to IDLE.
- Latency:
  - A req sampled at IDLE edge k gives grant after edge k.
  - done is high in the cycle after edge k+2.
  - Minimum of 4 cycles per operation, including the IDLE arbitration cycle.
- Abort:
  - If req[g] is low at the end of ISSUE or CAPTURE, go to IDLE with grant=0.
  - No done pulse, match unchanged, no counter update, pointer not rolled back.
- Requests arriving while busy are held pending and arbitrated in the next IDLE.
- Simultaneous events:
  - clr_cnt and an increment in the same cycle: the clear wins, so the counter is 0.
  - Multiple eligible requests resolve strictly round-robin from the pointer.
- Reset mid-operation: immediate return to the reset values; no done pulse is emitted.
- Operands are never registered internally; requesters must hold a/b stable from req until done.

Test Plan:
- Single request: req[2]=1, a=5, b=5 from reset → grant=0100 next cycle, cmp_en high for 1 cycle, done[2] pulse 3 cycles after the sample, match=1, match_cnt=1.
- Fairness: req=1111 held, each requester drops req for 1 cycle after its done and re-raises it → grants 0001, 0010, 0100, 1000, 0001; no requester granted twice in a row.
- Four-phase rule: req[0] held high after done with a≠b → no regrant until req[0] goes low for ≥1 cycle; miss_cnt increments exactly once.
- Abort: req[1] dropped during ISSUE → grant clears next cycle, no done, counters unchanged, next eligible requester served.
- Saturation: 260 matching operations with CNT_W=8 → match_cnt stays 255; clr_cnt asserted in the same cycle as a match → match_cnt=0.
- Reset mid-op: reset pulled low during CAPTURE → grant, done, cmp_en and counters are 0 immediately; after release a fresh req[3] is served starting from pointer 0.

Source files
------------

// File: rtl/validity_arbiter.sv
// Round-robin front end that time-shares one registered equality comparator
// among N_REQ four-phase requesters and keeps saturating match/miss counters.
module validity_arbiter #(
   parameter int unsigned N_REQ = 4,
   parameter int unsigned WIDTH = 3,
   parameter int unsigned CNT_W = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [N_REQ-1:0]       req,
   input  logic [N_REQ*WIDTH-1:0] a_flat,
   input  logic [N_REQ*WIDTH-1:0] b_flat,
   input  logic                   clr_cnt,
   output logic [N_REQ-1:0]       grant,
   output logic [WIDTH-1:0]       cmp_a,
   output logic [WIDTH-1:0]       cmp_b,
   output logic                   cmp_en,
   input  logic                   cmp_result,
   output logic [N_REQ-1:0]       done,
   output logic                   match,
   output logic                   busy,
   output logic [CNT_W-1:0]       match_cnt,
   output logic [CNT_W-1:0]       miss_cnt
);

   localparam int unsigned PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_CAPTURE, S_RESP} state_t;

   state_t           r_state;
   logic [N_REQ-1:0] r_grant;
   logic [N_REQ-1:0] r_done;
   logic [N_REQ-1:0] r_served;
   logic [PW-1:0]    r_ptr;
   logic             r_match;
   logic             r_cmp_en;
   logic [CNT_W-1:0] r_match_cnt;
   logic [CNT_W-1:0] r_miss_cnt;

   logic [N_REQ-1:0] w_elig;
   logic             w_any;
   logic [PW-1:0]    w_pick_idx;
   logic [N_REQ-1:0] w_pick_oh;
   logic [PW-1:0]    w_ptr_nxt;
   logic             w_abort;
   logic [WIDTH-1:0] w_cmp_a;
   logic [WIDTH-1:0] w_cmp_b;
   int unsigned      w_idx;

   assign w_elig = req & ~r_served;

   // First eligible index at or after the pointer, wrapping.
   always_comb begin
      w_any      = 1'b0;
      w_pick_idx = '0;
      w_idx      = 0;
      for (int unsigned k = 0; k < N_REQ; k++) begin
         w_idx = (32'(r_ptr) + k) % N_REQ;
         if (!w_any && w_elig[PW'(w_idx)]) begin
            w_any      = 1'b1;
            w_pick_idx = PW'(w_idx);
         end
      end
   end

   assign w_pick_oh = N_REQ'(1) << w_pick_idx;
   assign w_ptr_nxt = (w_pick_idx == PW'(N_REQ - 1)) ? '0 : w_pick_idx + 1'b1;
   assign w_abort   = ~|(req & r_grant);

   always_comb begin
      w_cmp_a = '0;
      w_cmp_b = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         if (r_grant[i]) begin
            w_cmp_a = w_cmp_a | a_flat[i*WIDTH +: WIDTH];
            w_cmp_b = w_cmp_b | b_flat[i*WIDTH +: WIDTH];
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= S_IDLE;
         r_grant     <= '0;
         r_done      <= '0;
         r_served    <= '0;
         r_ptr       <= '0;
         r_match     <= 1'b0;
         r_cmp_en    <= 1'b0;
         r_match_cnt <= '0;
         r_miss_cnt  <= '0;
      end else begin
         // A served bit survives only while its request stays high.
         r_served <= req & (r_served | r_done);
         r_done   <= '0;
         r_cmp_en <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_any) begin
                  r_grant  <= w_pick_oh;
                  r_ptr    <= w_ptr_nxt;
                  r_cmp_en <= 1'b1;
                  r_state  <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (w_abort) begin
                  r_grant <= '0;
                  r_state <= S_IDLE;
               end else begin
                  r_state <= S_CAPTURE;
               end
            end
            S_CAPTURE: begin
               if (w_abort) begin
                  r_grant <= '0;
                  r_state <= S_IDLE;
               end else begin
                  r_match <= cmp_result;
                  r_done  <= r_grant;
                  r_state <= S_RESP;
                  if (cmp_result) begin
                     if (r_match_cnt != '1) r_match_cnt <= r_match_cnt + 1'b1;
                  end else begin
                     if (r_miss_cnt != '1) r_miss_cnt <= r_miss_cnt + 1'b1;
                  end
               end
            end
            S_RESP: begin
               r_grant <= '0;
               r_state <= S_IDLE;
            end
            default: begin
               r_grant <= '0;
               r_state <= S_IDLE;
            end
         endcase
         // Placed last so a clear overrides a same-cycle increment.
         if (clr_cnt) begin
            r_match_cnt <= '0;
            r_miss_cnt  <= '0;
         end
      end
   end

   assign grant     = r_grant;
   assign done      = r_done;
   assign match     = r_match;
   assign cmp_en    = r_cmp_en;
   assign cmp_a     = w_cmp_a;
   assign cmp_b     = w_cmp_b;
   assign busy      = (r_state != S_IDLE);
   assign match_cnt = r_match_cnt;
   assign miss_cnt  = r_miss_cnt;

endmodule

// File: tb/tb_validity_arbiter.sv
// Directed bench for validity_arbiter with a behavioural registered comparator.
module tb_validity_arbiter;

   localparam int NR = 4;
   localparam int W  = 3;
   localparam int CW = 8;

   logic          clk;
   logic          reset;
   logic [NR-1:0] req;
   logic [NR*W-1:0] a_flat;
   logic [NR*W-1:0] b_flat;
   logic          clr_cnt;
   logic [NR-1:0] grant;
   logic [W-1:0]  cmp_a;
   logic [W-1:0]  cmp_b;
   logic          cmp_en;
   logic          cmp_result;
   logic [NR-1:0] done;
   logic          match;
   logic          busy;
   logic [CW-1:0] match_cnt;
   logic [CW-1:0] miss_cnt;

   int checks = 0;
   int errors = 0;

   validity_arbiter #(.N_REQ(NR), .WIDTH(W), .CNT_W(CW)) dut (
      .clk(clk), .reset(reset), .req(req), .a_flat(a_flat), .b_flat(b_flat),
      .clr_cnt(clr_cnt), .grant(grant), .cmp_a(cmp_a), .cmp_b(cmp_b),
      .cmp_en(cmp_en), .cmp_result(cmp_result), .done(done), .match(match),
      .busy(busy), .match_cnt(match_cnt), .miss_cnt(miss_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk or negedge reset) begin
      if (!reset) cmp_result <= 1'b0;
      else if (cmp_en) cmp_result <= (cmp_a == cmp_b);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_ab(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
      a_flat[i*W +: W] = a;
      b_flat[i*W +: W] = b;
   endtask

   task automatic wait_grant(input int maxc);
      for (int c = 0; c < maxc; c++) begin
         if (grant != '0) break;
         tick();
      end
   endtask

   task automatic wait_done(input int maxc);
      for (int c = 0; c < maxc; c++) begin
         if (done != '0) break;
         tick();
      end
   endtask

   logic [NR-1:0] fair_exp [5];

   initial begin
      fair_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      reset = 1'b0; req = '0; a_flat = '0; b_flat = '0; clr_cnt = 1'b0;
      tick(); tick();
      chk("rst_grant", 32'(grant), 32'h0);
      chk("rst_done", 32'(done), 32'h0);
      chk("rst_cmp_en", 32'(cmp_en), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_match", 32'(match), 32'h0);
      chk("rst_cnt", 32'({match_cnt, miss_cnt}), 32'h0);

      // Single request on requester 2
      reset = 1'b1;
      set_ab(2, 3'd5, 3'd5);
      req = 4'b0100;
      chk("idle_cmp_a", 32'(cmp_a), 32'h0);
      tick();
      chk("s1_grant", 32'(grant), 32'b0100);
      chk("s1_cmp_en", 32'(cmp_en), 32'h1);
      chk("s1_cmp_a", 32'(cmp_a), 32'h5);
      chk("s1_cmp_b", 32'(cmp_b), 32'h5);
      tick();
      chk("s1_cmp_en_low", 32'(cmp_en), 32'h0);
      chk("s1_no_done_yet", 32'(done), 32'h0);
      tick();
      chk("s1_done", 32'(done), 32'b0100);
      chk("s1_match", 32'(match), 32'h1);
      chk("s1_match_cnt", 32'(match_cnt), 32'h1);
      req = 4'b0000;
      tick();
      chk("s1_done_clear", 32'(done), 32'h0);
      chk("s1_grant_clear", 32'(grant), 32'h0);
      chk("s1_busy_clear", 32'(busy), 32'h0);

      // Four-phase rule on requester 0 (mismatch)
      set_ab(0, 3'd1, 3'd2);
      req = 4'b0001;
      tick();
      chk("fp_grant", 32'(grant), 32'b0001);
      wait_done(6);
      chk("fp_done", 32'(done), 32'b0001);
      chk("fp_match", 32'(match), 32'h0);
      chk("fp_miss_cnt", 32'(miss_cnt), 32'h1);
      repeat (5) tick();
      chk("fp_no_regrant", 32'(grant), 32'h0);
      chk("fp_no_busy", 32'(busy), 32'h0);
      chk("fp_miss_once", 32'(miss_cnt), 32'h1);
      req = 4'b0000;
      tick();
      req = 4'b0001;
      tick();
      chk("fp_regrant", 32'(grant), 32'b0001);
      wait_done(6);
      chk("fp_miss_cnt2", 32'(miss_cnt), 32'h2);
      req = 4'b0000;
      tick();

      // Fairness from a fresh pointer
      reset = 1'b0;
      #1;
      reset = 1'b1;
      for (int i = 0; i < NR; i++) set_ab(i, W'(i), W'(i));
      req = 4'b1111;
      for (int n = 0; n < 5; n++) begin
         wait_grant(8);
         chk($sformatf("fair_grant%0d", n), 32'(grant), 32'(fair_exp[n]));
         wait_done(6);
         chk($sformatf("fair_done%0d", n), 32'(done), 32'(fair_exp[n]));
         req = req & ~fair_exp[n];
         tick();
         req = req | fair_exp[n];
      end
      chk("fair_match_cnt", 32'(match_cnt), 32'h5);
      req = 4'b0000;
      tick(); tick();

      // Abort: requester 1 drops during ISSUE, requester 2 follows
      set_ab(2, 3'd3, 3'd4);
      req = 4'b0110;
      tick();
      chk("ab_grant1", 32'(grant), 32'b0010);
      req = 4'b0100;
      tick();
      chk("ab_grant_clear", 32'(grant), 32'h0);
      chk("ab_no_done", 32'(done), 32'h0);
      chk("ab_cmp_en", 32'(cmp_en), 32'h0);
      chk("ab_match_held", 32'(match), 32'h1);
      chk("ab_cnt_unchanged", 32'({match_cnt, miss_cnt}), 32'h0500);
      tick();
      chk("ab_grant2", 32'(grant), 32'b0100);
      wait_done(6);
      chk("ab_done2", 32'(done), 32'b0100);
      chk("ab_miss_cnt", 32'(miss_cnt), 32'h1);
      req = 4'b0000;
      tick();

      // Saturation on requester 3
      set_ab(3, 3'd3, 3'd3);
      for (int n = 0; n < 260; n++) begin
         req = 4'b1000;
         wait_done(6);
         req = 4'b0000;
         tick();
         if (n == 9) chk("sat_mid", 32'(match_cnt), 32'd15);
         if (n == 249) chk("sat_reach", 32'(match_cnt), 32'd255);
      end
      chk("sat_hold", 32'(match_cnt), 32'd255);
      req = 4'b1000;
      tick();
      tick();
      clr_cnt = 1'b1;
      tick();
      chk("clr_done", 32'(done), 32'b1000);
      chk("clr_wins", 32'(match_cnt), 32'h0);
      chk("clr_miss", 32'(miss_cnt), 32'h0);
      clr_cnt = 1'b0;
      req = 4'b0000;
      tick();

      // Reset during CAPTURE
      req = 4'b0010;
      wait_done(8);
      chk("rm_pre_cnt", 32'(match_cnt), 32'h1);
      req = 4'b0000;
      tick();
      req = 4'b0100;
      tick();
      chk("rm_grant", 32'(grant), 32'b0100);
      tick();
      reset = 1'b0;
      #1;
      chk("rm_grant0", 32'(grant), 32'h0);
      chk("rm_done0", 32'(done), 32'h0);
      chk("rm_cmp_en0", 32'(cmp_en), 32'h0);
      chk("rm_cnt0", 32'({match_cnt, miss_cnt}), 32'h0);
      chk("rm_busy0", 32'(busy), 32'h0);
      req = 4'b0000;
      tick();
      reset = 1'b1;
      req = 4'b1001;
      tick();
      chk("rm_ptr0_grant", 32'(grant), 32'b0001);
      wait_done(6);
      req = 4'b1000;
      tick();
      wait_grant(8);
      chk("rm_grant3", 32'(grant), 32'b1000);
      wait_done(6);
      chk("rm_done3", 32'(done), 32'b1000);
      chk("rm_match_cnt", 32'(match_cnt), 32'h2);
      req = 4'b0000;
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
